// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit-instruction core: program select, PC load, clock-enable gating,
// end/timeout detection and data-memory arbitration between the core and an external loader.
module prog_sequencer #(
    parameter int D          = 10,
    parameter int CW         = 16,
    parameter int P0_START   = 0,
    parameter int P0_END     = 400,
    parameter int P1_START   = 400,
    parameter int P1_END     = 450,
    parameter int P2_START   = 450,
    parameter int P2_END     = 800,
    parameter int MAX_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic [D-1:0]  pc,
    output logic          pc_load,
    output logic [D-1:0]  pc_load_val,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    input  logic          ext_req,
    output logic          ext_gnt
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_TOUT} state_t;

    localparam logic [D-1:0]  A_P0_S = D'(P0_START);
    localparam logic [D-1:0]  A_P0_E = D'(P0_END);
    localparam logic [D-1:0]  A_P1_S = D'(P1_START);
    localparam logic [D-1:0]  A_P1_E = D'(P1_END);
    localparam logic [D-1:0]  A_P2_S = D'(P2_START);
    localparam logic [D-1:0]  A_P2_E = D'(P2_END);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_prog;
    logic [CW-1:0] r_cycle_count;
    logic          r_ext_gnt;

    logic [D-1:0]  w_start_addr;
    logic [D-1:0]  w_end_addr;
    logic          w_idle_like;
    logic          w_accept;
    logic          w_hit;
    logic          w_limit;

    always_comb begin
        w_start_addr = A_P0_S;
        w_end_addr   = A_P0_E;
        case (r_prog)
            2'd1: begin
                w_start_addr = A_P1_S;
                w_end_addr   = A_P1_E;
            end
            2'd2: begin
                w_start_addr = A_P2_S;
                w_end_addr   = A_P2_E;
            end
            default: begin
                w_start_addr = A_P0_S;
                w_end_addr   = A_P0_E;
            end
        endcase
    end

    // A grant blocks starts, and a start on the same edge blocks a new grant.
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TOUT);
    assign w_accept    = w_idle_like && start && (prog_sel != 2'd3) && !r_ext_gnt;
    assign w_hit       = (r_state == S_RUN) && (pc == w_end_addr);
    assign w_limit     = (r_cycle_count == LAST_COUNT);

    always_comb begin
        w_state_next = r_state;
        pc_load      = 1'b0;
        pc_load_val  = '0;
        core_en      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_TOUT: begin
                done    = (r_state == S_DONE);
                timeout = (r_state == S_TOUT);
                if (w_accept) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                pc_load      = 1'b1;
                pc_load_val  = w_start_addr;
                busy         = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                core_en = !w_hit;
                if (w_hit) begin
                    w_state_next = S_DONE;
                end else if (w_limit) begin
                    w_state_next = S_TOUT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_prog        <= 2'd0;
            r_cycle_count <= '0;
            r_ext_gnt     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_prog <= prog_sel;
            end
            // Saturating count of enabled RUN cycles; the hit cycle is not counted.
            if (w_accept || r_state == S_LOAD) begin
                r_cycle_count <= '0;
            end else if (core_en && r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + CW'(1);
            end
            if (r_ext_gnt) begin
                r_ext_gnt <= ext_req;
            end else begin
                r_ext_gnt <= ext_req && w_idle_like && !w_accept;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign ext_gnt     = r_ext_gnt;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed plus randomized checks of prog_sequencer; core PC is modelled as a loadable counter.
module tb_prog_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          START_ADDR [3] = '{0, 400, 450};
    int          END_ADDR   [3] = '{400, 450, 800};

    // Instance A: default limits
    logic        start_a = 1'b0;
    logic [1:0]  sel_a = 2'd0;
    logic [9:0]  pc_a = '0;
    logic        adv_a = 1'b1;
    logic        ext_req_a = 1'b0;
    logic        pc_load_a, core_en_a, busy_a, done_a, timeout_a, ext_gnt_a;
    logic [9:0]  pc_load_val_a;
    logic [15:0] cycle_count_a;

    // Instance T: short timeout, PC held off the end address
    logic        start_t = 1'b0;
    logic [1:0]  sel_t = 2'd0;
    logic [9:0]  pc_t = 10'd460;
    logic        ext_req_t = 1'b0;
    logic        pc_load_t, core_en_t, busy_t, done_t, timeout_t, ext_gnt_t;
    logic [9:0]  pc_load_val_t;
    logic [15:0] cycle_count_t;

    always #5 clk = ~clk;

    prog_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start_a), .prog_sel(sel_a), .pc(pc_a),
        .pc_load(pc_load_a), .pc_load_val(pc_load_val_a), .core_en(core_en_a),
        .busy(busy_a), .done(done_a), .timeout(timeout_a), .cycle_count(cycle_count_a),
        .ext_req(ext_req_a), .ext_gnt(ext_gnt_a)
    );

    prog_sequencer #(.MAX_CYCLES(20)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .prog_sel(sel_t), .pc(pc_t),
        .pc_load(pc_load_t), .pc_load_val(pc_load_val_t), .core_en(core_en_t),
        .busy(busy_t), .done(done_t), .timeout(timeout_t), .cycle_count(cycle_count_t),
        .ext_req(ext_req_t), .ext_gnt(ext_gnt_t)
    );

    always @(posedge clk) begin
        if (pc_load_a) pc_a <= pc_load_val_a;
        else if (core_en_a && adv_a) pc_a <= pc_a + 10'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected cycle count = distance to END plus every enabled cycle in which the core stalled.
    task automatic run_a(input int prog, input bit stalls, input bit with_req);
        int  stall_n;
        int  cyc;
        bit  fin;
        @(negedge clk);
        start_a   = 1'b1;
        sel_a     = prog[1:0];
        ext_req_a = with_req;
        @(negedge clk);
        start_a = 1'b0;
        check("load_pulse", pc_load_a, 1);
        check("load_val", pc_load_val_a, START_ADDR[prog]);
        check("load_flags_clear", {done_a, timeout_a}, 0);
        check("load_count_zero", cycle_count_a, 0);
        check("load_core_en", core_en_a, 0);
        check("load_gnt", ext_gnt_a, 0);
        @(negedge clk);
        check("run_pc_start", pc_a, START_ADDR[prog]);
        check("run_core_en", core_en_a, 1);
        check("run_no_pulse", pc_load_a, 0);
        stall_n = 0;
        cyc     = 0;
        fin     = 1'b0;
        while (!fin && cyc < 3000) begin
            if (busy_a && pc_a == 10'(END_ADDR[prog])) begin
                check("hit_core_en", core_en_a, 0);
                check("hit_not_done", done_a, 0);
            end
            if (with_req && busy_a) check("gnt_while_busy", ext_gnt_a, 0);
            adv_a = stalls ? ($urandom_range(3) != 0) : 1'b1;
            if (core_en_a && !adv_a) stall_n++;
            @(negedge clk);
            cyc++;
            if (done_a || timeout_a) fin = 1'b1;
        end
        adv_a = 1'b1;
        check("run_bounded", fin, 1);
        check("done_flag", done_a, 1);
        check("no_timeout", timeout_a, 0);
        check("cycle_count", cycle_count_a, END_ADDR[prog] - START_ADDR[prog] + stall_n);
        check("done_core_en", core_en_a, 0);
        check("done_not_busy", busy_a, 0);
    endtask

    initial begin
        int  cyc;
        int  n_run;
        int  p;
        bit  prev_done;

        reset = 1'b1;
        #1;
        check("rst_outputs",
              {pc_load_a, core_en_a, busy_a, done_a, timeout_a, ext_gnt_a}, 0);
        check("rst_load_val", pc_load_val_a, 0);
        check("rst_count", cycle_count_a, 0);
        @(negedge clk);
        reset = 1'b0;

        // Program 1, then done is held
        run_a(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("done_held", done_a, 1);
        check("done_held_count", cycle_count_a, 50);

        // Asynchronous reset mid-RUN of program 2
        @(negedge clk);
        start_a = 1'b1;
        sel_a   = 2'd2;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (cycle_count_a != 16'd37 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach37", cycle_count_a, 37);
        check("rst_pre_busy", busy_a, 1);
        #2 reset = 1'b1;
        #1;
        check("async_core_en", core_en_a, 0);
        check("async_busy", busy_a, 0);
        check("async_count", cycle_count_a, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {busy_a, done_a, timeout_a, pc_load_a}, 0);

        // Invalid program index is ignored
        start_a = 1'b1;
        sel_a   = 2'd3;
        @(negedge clk);
        start_a = 1'b0;
        check("sel3_ignored",
              {pc_load_a, core_en_a, busy_a, done_a, timeout_a, ext_gnt_a}, 0);
        check("sel3_count", cycle_count_a, 0);

        // Program 0, then back-to-back program 2 from DONE
        run_a(0, 1'b0, 1'b0);
        run_a(2, 1'b0, 1'b0);

        // Arbitration
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ext_req_a = 1'b1;
        @(negedge clk);
        check("gnt_idle", ext_gnt_a, 1);
        start_a = 1'b1;
        sel_a   = 2'd1;
        @(negedge clk);
        start_a = 1'b0;
        check("start_blocked", {pc_load_a, busy_a}, 0);
        check("gnt_kept", ext_gnt_a, 1);
        ext_req_a = 1'b0;
        @(negedge clk);
        check("gnt_drop", ext_gnt_a, 0);
        run_a(1, 1'b0, 1'b1);
        check("gnt_at_done_entry", ext_gnt_a, 0);
        @(negedge clk);
        check("gnt_after_done", ext_gnt_a, 1);
        ext_req_a = 1'b0;
        @(negedge clk);
        check("gnt_release", ext_gnt_a, 0);

        // Timeout on the short-limit instance
        start_t = 1'b1;
        sel_t   = 2'd2;
        @(negedge clk);
        start_t = 1'b0;
        check("t_load_pulse", pc_load_t, 1);
        check("t_load_val", pc_load_val_t, 450);
        n_run = 0;
        cyc   = 0;
        while (!timeout_t && !done_t && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy_t) n_run++;
        end
        check("t_flag", timeout_t, 1);
        check("t_run_cycles", n_run, 20);
        check("t_count", cycle_count_t, 20);
        check("t_core_en", core_en_t, 0);
        check("t_done", done_t, 0);
        repeat (2) @(negedge clk);
        check("t_held", {timeout_t, cycle_count_t}, {1'b1, 16'd20});

        // Randomized runs with random core stalls
        for (int k = 0; k < 6; k++) begin
            p = int'($urandom_range(3));
            if (p == 3) begin
                prev_done = done_a;
                @(negedge clk);
                start_a = 1'b1;
                sel_a   = 2'd3;
                @(negedge clk);
                start_a = 1'b0;
                check("rnd_sel3", {pc_load_a, busy_a, done_a}, {2'b00, prev_done});
            end else begin
                run_a(p, 1'b1, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller for the 9-bit-instruction CPU core. Sequences execution of the three resident programs:
  - selects a program,
  - loads its start address into the program counter,
  - gates the core clock-enable,
  - detects end-of-program,
  - reports done, timeout and the cycle count.
- Arbitrates data-memory ownership between the core and an external loader/checker. The loader may own memory only while the core is not running.

Parameters:
- D, 10, program counter width.
- CW, 16, cycle counter width.
- P0_START, 0, program 0 start address.
- P0_END, 400, program 0 end address.
- P1_START, 400, program 1 start address.
- P1_END, 450, program 1 end address.
- P2_START, 450, program 2 start address.
- P2_END, 800, program 2 end address.
- MAX_CYCLES, 50000, run-cycle limit before timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled on the rising edge.
- prog_sel  input  2  program index 0..2; 3 is invalid.
- pc  input  D  current program counter from the core.
- pc_load  output  1  one-cycle pulse: core PC takes pc_load_val.
- pc_load_val  output  D  start address of the selected program.
- core_en  output  1  core advance enable; PC and register/memory writes are allowed only when high.
- busy  output  1  high in LOAD or RUN.
- done  output  1  high in DONE.
- timeout  output  1  high in TOUT.
- cycle_count  output  CW  number of RUN cycles in the current/last run.
- ext_req  input  1  external data-memory access request.
- ext_gnt  output  1  external port owns data memory (data-memory mux select).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - pc_load=0, pc_load_val=0, core_en=0, busy=0, done=0, timeout=0, cycle_count=0, ext_gnt=0.
  - All outputs take these values immediately, without waiting for clk.
- States: IDLE, LOAD, RUN, DONE, TOUT. State is registered; outputs are decoded from state except core_en (see RUN).
- IDLE/DONE/TOUT, start accept rule:
  - Accept start when start=1, prog_sel<3 and ext_gnt=0.
  - On accept: go to LOAD next cycle and latch prog_sel internally.
  - start with prog_sel=3: ignored, state unchanged.
  - start while ext_gnt=1: ignored.
- LOAD (exactly 1 cycle):
  - pc_load=1; pc_load_val = start address of the latched program.
  - core_en=0; cycle_count cleared to 0; done and timeout clear on entry.
  - Next state: RUN.
- RUN:
  - hit = (pc == END address of the latched program).
  - core_en = !hit, combinational, so the core freezes in the cycle the end address appears.
  - cycle_count increments each RUN cycle in which core_en=1.
  - If hit: next state DONE, and cycle_count does not increment.
  - Else if cycle_count == MAX_CYCLES-1 on an incrementing edge: next state TOUT (count reaches MAX_CYCLES).
  - hit takes priority over timeout in the same cycle.
  - start is ignored in RUN.
- DONE / TOUT:
  - core_en=0.
  - done (resp. timeout) is held until the next accepted start or reset.
  - cycle_count holds its final value.
- Latency:
  - Start accepted at edge N → pc_load high in cycle N+1 → core_en high from cycle N+2.
  - pc reaching END → done high one edge later.
- Arbitration:
  - ext_gnt is registered.
  - It is set on the edge where ext_req=1 and state ∈ {IDLE, DONE, TOUT}, and no start is being accepted on that same edge.
  - It clears on the first edge with ext_req=0.
  - If start and ext_req rise in the same cycle while ext_gnt=0: start wins. ext_req waits until the run finishes and is granted in DONE/TOUT.
  - ext_gnt is never 1 while busy=1.
- Width rules:
  - pc compare is D bits, unsigned.
  - cycle_count saturates; it never wraps.
  - Start/end addresses are truncated to D bits.

Test Plan:
- Reset mid-RUN (program 2, cycle_count=37), assert reset without clk edge → core_en=0, busy=0, cycle_count=0 immediately; state IDLE after release.
- start=1, prog_sel=1; PC model increments when core_en=1 → pc_load pulse 1 cycle with pc_load_val=400. Core_en drops in the cycle pc=450; done=1 next edge; cycle_count=50; done held until next start.
- prog_sel=3 with start=1 → no pc_load, state IDLE, all outputs 0. Then prog_sel=0 → pc_load_val=0; run ends at pc=400 with cycle_count=400.
- MAX_CYCLES=20, prog_sel=2, PC model stalled at 460 → timeout=1 after 20 RUN cycles, cycle_count=20, core_en=0, done=0.
- Arbitration: ext_req=1 in IDLE → ext_gnt=1 next edge, and a start while granted is ignored. Drop ext_req → ext_gnt=0. Then start and ext_req asserted in the same cycle → LOAD entered, ext_gnt stays 0 through RUN, ext_gnt=1 one edge after DONE is entered.
- Back-to-back: start in DONE (program 0 finished) with prog_sel=2 → done clears in LOAD, pc_load_val=450, new run ends at pc=800 with cycle_count=350.
